udp_rx_handler: RTL and testbench
=================================

# udp_rx_handler

Downstream stage of the Ethernet/IPv4 receive handler. Consumes the IPv4 payload byte stream and the per-packet IPv4 metadata, parses and strips the 8-byte UDP header, and verifies the UDP checksum over the IPv4 pseudo-header, header and payload. Forwards only the UDP payload on its output stream, then publishes per-datagram UDP metadata under a valid/ready handshake. Non-UDP packets and datagrams with an inconsistent length are consumed and dropped.

## Interface
- DATA_WIDTH, `INPUTWIDTH (8): stream width in bits; only 8 supported; non-8 is an elaboration error.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_axis  axi_stream_if slave  DATA_WIDTH  IPv4 payload bytes (tdata/tvalid/tready/tlast); tlast on final payload byte.
- in_meta_valid  input  1  IPv4 metadata valid.
- in_meta_ready  output  1  one-cycle pulse: metadata and packet fully consumed.
- in_meta_src_ip, in_meta_dst_ip  input  32  IPv4 addresses.
- in_meta_protocol  input  8  IPv4 protocol.
- in_meta_total_length  input  16  IPv4 total length (IHL fixed at `IPV4_IHL_DEFAULT`).
- m_axis  axi_stream_if master  DATA_WIDTH  UDP payload bytes.
- udp_meta_valid  output  1  UDP metadata valid; held until udp_meta_ready.
- udp_meta_ready  input  1  consumer acknowledge.
- udp_src_port, udp_dst_port, udp_length  output  16  header fields.
- udp_checksum_ok  output  1  checksum passed or not transmitted (field == 0).
- udp_length_err  output  1  udp_length < 8, > IPv4 payload length, or stream ended early.
- udp_drop  output  1  datagram not forwarded (non-UDP or length error).

## Operation
- IDLE: s_axis.tready=0. On in_meta_valid: latch IPs, ip_payload_len = in_meta_total_length − 4·IHL. If protocol ≠ 0x11 → DROP with udp_drop=1; else → HDR.
- HDR: s_axis.tready=1; capture 8 bytes big-endian (src port, dst port, length, checksum). After byte 8: if length < 8 or > ip_payload_len → length_err=1, drop=1, DROP; else remaining = length − 8 → PAYLOAD (→ META directly if remaining=0 and tlast seen, → TRAIL if remaining=0 without tlast). tlast within header → length_err, drop, META.
- PAYLOAD: pass-through, m_axis.tdata=s_axis.tdata, m_axis.tvalid=s_axis.tvalid, s_axis.tready=m_axis.tready. m_axis.tlast=1 on byte where remaining=1, or on early s_axis.tlast (sets length_err; drop stays 0). After last forwarded byte: → META if input tlast seen, else TRAIL.
- TRAIL / DROP: s_axis.tready=1, discard bytes (IPv4 padding) until tlast → META. Trailing bytes excluded from checksum.
- META: udp_meta_valid=1, outputs stable; on udp_meta_ready: pulse in_meta_ready, → IDLE.
- Checksum: 32-bit accumulator seeded with src_ip[31:16]+src_ip[15:0]+dst_ip[31:16]+dst_ip[15:0]+0x0011+udp_length; add 16-bit big-endian words of header (checksum field included) and payload; odd final byte padded low with 0x00. End-around-carry fold twice; ok if folded == 0xFFFF or header checksum == 0x0000. Non-UDP: ok=0.

## Timing
- Reset: state IDLE; all outputs 0 (s_axis.tready, m_axis.tvalid/tlast/tdata, in_meta_ready, udp_meta_valid, fields, flags).
- Payload latency 0 cycles (combinational pass-through); backpressure propagates combinationally.
- udp_meta_valid rises the cycle after the final input handshake (tlast); in_meta_ready pulses the same cycle udp_meta_valid && udp_meta_ready, for one cycle.
- No new in_meta accepted until return to IDLE (≥1 idle cycle between packets).
- Reset mid-packet: immediate return to IDLE, outputs cleared; remaining input bytes of that packet are not specially handled.

## Test plan
- UDP, total_length 48, udp_length 28, valid checksum, 20 payload bytes → 20 bytes on m_axis, tlast on 20th, ports/length match, checksum_ok=1, drop=0.
- Same datagram with one payload bit flipped → identical payload forwarded, checksum_ok=0.
- Checksum field 0x0000, odd udp_length 29 → 21 bytes forwarded, checksum_ok=1.
- protocol 0x06 → no m_axis beats, all input bytes consumed, udp_drop=1, udp_meta_valid asserted, in_meta_ready pulses after ack.
- udp_length 40 with ip payload 28 → length_err=1, drop=1, zero m_axis beats; udp_length 20 with ip payload 28 → 12 bytes forwarded, 8 padding bytes discarded.
- m_axis.tready toggled randomly, udp_meta_ready delayed 10 cycles → no byte lost/duplicated; metadata held stable for all 10 cycles.

Source files
------------

// File: rtl/udp_rx_handler.sv
// UDP receive stage: strips the 8-byte UDP header from an IPv4 payload stream, forwards the
// UDP payload combinationally, verifies the checksum and publishes per-datagram metadata.
module udp_rx_handler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic                  s_axis_tlast_i,
    input  logic                  in_meta_valid_i,
    output logic                  in_meta_ready_o,
    input  logic [31:0]           in_meta_src_ip_i,
    input  logic [31:0]           in_meta_dst_ip_i,
    input  logic [7:0]            in_meta_protocol_i,
    input  logic [15:0]           in_meta_total_length_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tlast_o,
    output logic                  udp_meta_valid_o,
    input  logic                  udp_meta_ready_i,
    output logic [15:0]           udp_src_port_o,
    output logic [15:0]           udp_dst_port_o,
    output logic [15:0]           udp_length_o,
    output logic                  udp_checksum_ok_o,
    output logic                  udp_length_err_o,
    output logic                  udp_drop_o
);

    localparam logic [15:0] IPV4_HDR_BYTES = 16'd20;  // IHL fixed at 5 words
    localparam logic [7:0]  PROTO_UDP      = 8'h11;

    if (DATA_WIDTH != 8) begin : g_width_check
        $error("udp_rx_handler supports DATA_WIDTH = 8 only");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_TRAIL, ST_DROP, ST_META} state_e;

    state_e      state_q, state_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] ip_len_q, ip_len_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] acc_q, acc_d;
    logic        phase_hi_q, phase_hi_d;
    logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d;
    logic [15:0] udp_len_q, udp_len_d, csum_field_q, csum_field_d;
    logic        is_udp_q, is_udp_d, len_err_q, len_err_d, drop_q, drop_d, csum_ok_q, csum_ok_d;

    logic [7:0]  in_byte;
    logic [31:0] byte_word;
    logic [16:0] fold1, fold2;

    assign in_byte   = s_axis_tdata_i[7:0];
    // Even-offset bytes are the high half of a big-endian word; an odd tail is thus zero-padded low.
    assign byte_word = phase_hi_q ? {16'h0, in_byte, 8'h00} : {24'h0, in_byte};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        hdr_cnt_d       = hdr_cnt_q;
        ip_len_d        = ip_len_q;
        remaining_d     = remaining_q;
        acc_d           = acc_q;
        phase_hi_d      = phase_hi_q;
        src_port_d      = src_port_q;
        dst_port_d      = dst_port_q;
        udp_len_d       = udp_len_q;
        csum_field_d    = csum_field_q;
        is_udp_d        = is_udp_q;
        len_err_d       = len_err_q;
        drop_d          = drop_q;
        csum_ok_d       = csum_ok_q;
        s_axis_tready_o = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = '0;
        m_axis_tlast_o  = 1'b0;
        in_meta_ready_o = 1'b0;
        udp_meta_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_meta_valid_i) begin
                    ip_len_d = (in_meta_total_length_i < IPV4_HDR_BYTES) ? 16'd0
                             : in_meta_total_length_i - IPV4_HDR_BYTES;
                    acc_d = {16'h0, in_meta_src_ip_i[31:16]} + {16'h0, in_meta_src_ip_i[15:0]}
                          + {16'h0, in_meta_dst_ip_i[31:16]} + {16'h0, in_meta_dst_ip_i[15:0]}
                          + {24'h0, PROTO_UDP};
                    phase_hi_d   = 1'b1;
                    hdr_cnt_d    = 3'd0;
                    src_port_d   = '0;
                    dst_port_d   = '0;
                    udp_len_d    = '0;
                    csum_field_d = '0;
                    len_err_d    = 1'b0;
                    csum_ok_d    = 1'b0;
                    is_udp_d     = (in_meta_protocol_i == PROTO_UDP);
                    drop_d       = (in_meta_protocol_i != PROTO_UDP);
                    state_d      = (in_meta_protocol_i == PROTO_UDP) ? ST_HDR : ST_DROP;
                end
            end
            ST_HDR: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i) begin
                    // Byte 5 completes udp_length, which the pseudo-header also counts once.
                    acc_d = acc_q + byte_word
                          + ((hdr_cnt_q == 3'd5) ? {16'h0, udp_len_q[15:8], in_byte} : 32'h0);
                    phase_hi_d = ~phase_hi_q;
                    hdr_cnt_d  = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0:    src_port_d[15:8]   = in_byte;
                        3'd1:    src_port_d[7:0]    = in_byte;
                        3'd2:    dst_port_d[15:8]   = in_byte;
                        3'd3:    dst_port_d[7:0]    = in_byte;
                        3'd4:    udp_len_d[15:8]    = in_byte;
                        3'd5:    udp_len_d[7:0]     = in_byte;
                        3'd6:    csum_field_d[15:8] = in_byte;
                        default: csum_field_d[7:0]  = in_byte;
                    endcase
                    if (hdr_cnt_q == 3'd7) begin
                        if (udp_len_q < 16'd8 || udp_len_q > ip_len_q) begin
                            len_err_d = 1'b1;
                            drop_d    = 1'b1;
                            state_d   = s_axis_tlast_i ? ST_META : ST_DROP;
                        end else begin
                            remaining_d = udp_len_q - 16'd8;
                            if (udp_len_q == 16'd8) begin
                                state_d = s_axis_tlast_i ? ST_META : ST_TRAIL;
                            end else if (s_axis_tlast_i) begin
                                len_err_d = 1'b1;
                                drop_d    = 1'b1;
                                state_d   = ST_META;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end else if (s_axis_tlast_i) begin
                        len_err_d = 1'b1;
                        drop_d    = 1'b1;
                        state_d   = ST_META;
                    end
                end
            end
            ST_PAYLOAD: begin
                m_axis_tdata_o  = s_axis_tdata_i;
                m_axis_tvalid_o = s_axis_tvalid_i;
                m_axis_tlast_o  = (remaining_q == 16'd1) || s_axis_tlast_i;
                s_axis_tready_o = m_axis_tready_i;
                if (s_axis_tvalid_i && m_axis_tready_i) begin
                    acc_d       = acc_q + byte_word;
                    phase_hi_d  = ~phase_hi_q;
                    remaining_d = remaining_q - 16'd1;
                    if (s_axis_tlast_i) begin
                        len_err_d = (remaining_q != 16'd1);
                        state_d   = ST_META;
                    end else if (remaining_q == 16'd1) begin
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL, ST_DROP: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i && s_axis_tlast_i) state_d = ST_META;
            end
            ST_META: begin
                udp_meta_valid_o = 1'b1;
                if (udp_meta_ready_i) begin
                    in_meta_ready_o = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fold1 = {1'b0, acc_d[31:16]} + {1'b0, acc_d[15:0]};
        fold2 = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};
        if (state_d == ST_META && state_q != ST_META) begin
            csum_ok_d = is_udp_q && (fold2[15:0] == 16'hFFFF || csum_field_d == 16'h0000);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hdr_cnt_q    <= '0;
            ip_len_q     <= '0;
            remaining_q  <= '0;
            acc_q        <= '0;
            phase_hi_q   <= 1'b1;
            src_port_q   <= '0;
            dst_port_q   <= '0;
            udp_len_q    <= '0;
            csum_field_q <= '0;
            is_udp_q     <= 1'b0;
            len_err_q    <= 1'b0;
            drop_q       <= 1'b0;
            csum_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            ip_len_q     <= ip_len_d;
            remaining_q  <= remaining_d;
            acc_q        <= acc_d;
            phase_hi_q   <= phase_hi_d;
            src_port_q   <= src_port_d;
            dst_port_q   <= dst_port_d;
            udp_len_q    <= udp_len_d;
            csum_field_q <= csum_field_d;
            is_udp_q     <= is_udp_d;
            len_err_q    <= len_err_d;
            drop_q       <= drop_d;
            csum_ok_q    <= csum_ok_d;
        end
    end

    assign udp_src_port_o    = src_port_q;
    assign udp_dst_port_o    = dst_port_q;
    assign udp_length_o      = udp_len_q;
    assign udp_checksum_ok_o = csum_ok_q;
    assign udp_length_err_o  = len_err_q;
    assign udp_drop_o        = drop_q;

endmodule

// File: tb/tb_udp_rx_handler.sv
// Directed bench for udp_rx_handler: builds datagrams with bench-computed checksums, drives
// them through the block and compares forwarded bytes and metadata with hand-derived values.
module tb_udp_rx_handler;

    localparam logic [31:0] SRC_IP = 32'hC0A8_0001;
    localparam logic [31:0] DST_IP = 32'hC0A8_00FE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic        in_meta_valid, in_meta_ready;
    logic [7:0]  in_proto;
    logic [15:0] in_total;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic        udp_meta_valid, udp_meta_ready;
    logic [15:0] src_port, dst_port, udp_len;
    logic        csum_ok, len_err, drop;

    always #5 clk = ~clk;

    udp_rx_handler #(.DATA_WIDTH(8)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_tdata_i         (s_tdata),
        .s_axis_tvalid_i        (s_tvalid),
        .s_axis_tready_o        (s_tready),
        .s_axis_tlast_i         (s_tlast),
        .in_meta_valid_i        (in_meta_valid),
        .in_meta_ready_o        (in_meta_ready),
        .in_meta_src_ip_i       (SRC_IP),
        .in_meta_dst_ip_i       (DST_IP),
        .in_meta_protocol_i     (in_proto),
        .in_meta_total_length_i (in_total),
        .m_axis_tdata_o         (m_tdata),
        .m_axis_tvalid_o        (m_tvalid),
        .m_axis_tready_i        (m_tready),
        .m_axis_tlast_o         (m_tlast),
        .udp_meta_valid_o       (udp_meta_valid),
        .udp_meta_ready_i       (udp_meta_ready),
        .udp_src_port_o         (src_port),
        .udp_dst_port_o         (dst_port),
        .udp_length_o           (udp_len),
        .udp_checksum_ok_o      (csum_ok),
        .udp_length_err_o       (len_err),
        .udp_drop_o             (drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0]  pkt [0:127];
    int          nbytes;
    logic [7:0]  got [$];
    int          last_cnt, last_pos, consumed, pulse_cnt, meta_wait, last_cons_cyc, first_valid_cyc;
    bit          stable, done;
    logic [15:0] snap_sp, snap_dp, snap_len;
    logic        snap_ok, snap_err, snap_drop;

    // Reference one's-complement checksum over pseudo-header and the first n datagram bytes.
    function automatic logic [15:0] calc_csum(input logic [15:0] ulen, input int n);
        logic [31:0] s;
        logic [15:0] r;
        s = {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]} + {16'h0, DST_IP[31:16]}
          + {16'h0, DST_IP[15:0]} + 32'h11 + {16'h0, ulen};
        for (int i = 0; i < n; i += 2)
            s += {16'h0, pkt[i], (i + 1 < n) ? pkt[i+1] : 8'h00};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        r = ~s[15:0];
        return (r == 16'h0) ? 16'hFFFF : r;
    endfunction

    task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen,
                         input int ndata, input int npad, input bit zero_ck);
        logic [15:0] ck;
        pkt[0] = sp[15:8];   pkt[1] = sp[7:0];
        pkt[2] = dp[15:8];   pkt[3] = dp[7:0];
        pkt[4] = ulen[15:8]; pkt[5] = ulen[7:0];
        pkt[6] = 8'h00;      pkt[7] = 8'h00;
        for (int i = 0; i < ndata; i++) pkt[8+i] = 8'(i * 13 + 7);
        for (int i = 0; i < npad; i++)  pkt[8+ndata+i] = 8'hEE;
        nbytes = 8 + ndata + npad;
        if (!zero_ck) begin
            ck = calc_csum(ulen, 8 + ndata);
            pkt[6] = ck[15:8];
            pkt[7] = ck[7:0];
        end
    endtask

    task automatic run_packet(input logic [7:0] proto, input logic [15:0] tot,
                              input bit rand_rdy, input int ack_delay);
        int in_idx, cycles;
        got.delete();
        last_cnt = 0; last_pos = -1; pulse_cnt = 0; meta_wait = 0; stable = 1'b1; done = 1'b0;
        last_cons_cyc = 0; first_valid_cyc = 0; in_idx = 0; cycles = 0;
        in_proto = proto; in_total = tot; in_meta_valid = 1'b1;
        while (!done && cycles < 3000) begin
            s_tvalid       = (in_idx < nbytes);
            s_tdata        = s_tvalid ? pkt[in_idx] : 8'h00;
            s_tlast        = (in_idx == nbytes - 1);
            m_tready       = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            udp_meta_ready = (meta_wait >= ack_delay);
            @(negedge clk);
            cycles++;
            if (in_meta_ready) pulse_cnt++;
            if (in_meta_valid && in_meta_ready) done = 1'b1;
            if (s_tvalid && s_tready) begin
                in_idx++;
                last_cons_cyc = cycles;
            end
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                if (m_tlast) begin
                    last_cnt++;
                    last_pos = got.size() - 1;
                end
            end
            if (udp_meta_valid) begin
                if (meta_wait == 0) begin
                    snap_sp = src_port; snap_dp = dst_port; snap_len = udp_len;
                    snap_ok = csum_ok;  snap_err = len_err; snap_drop = drop;
                    first_valid_cyc = cycles;
                end else if ({src_port, dst_port, udp_len, csum_ok, len_err, drop} !==
                             {snap_sp, snap_dp, snap_len, snap_ok, snap_err, snap_drop}) begin
                    stable = 1'b0;
                end
                meta_wait++;
            end
            @(posedge clk);
            #1;
        end
        in_meta_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; udp_meta_ready = 1'b0;
        consumed = in_idx;
        check("handshake_done", 32'(done), 32'd1);
        @(negedge clk);
        if (in_meta_ready) pulse_cnt++;
        check("idle_after_ack", 32'(udp_meta_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int exp_fwd, input logic exp_ok,
                                input logic exp_err, input logic exp_drop, input bit chk_fields,
                                input logic [15:0] exp_sp, input logic [15:0] exp_dp,
                                input logic [15:0] exp_len);
        check({tag, ".beats"}, 32'(got.size()), 32'(exp_fwd));
        for (int i = 0; i < exp_fwd && i < got.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), {24'h0, got[i]}, {24'h0, pkt[8+i]});
        check({tag, ".tlast_cnt"}, 32'(last_cnt), (exp_fwd > 0) ? 32'd1 : 32'd0);
        if (exp_fwd > 0) check({tag, ".tlast_pos"}, 32'(last_pos), 32'(exp_fwd - 1));
        check({tag, ".consumed"}, 32'(consumed), 32'(nbytes));
        check({tag, ".ready_pulses"}, 32'(pulse_cnt), 32'd1);
        check({tag, ".meta_latency"}, 32'(first_valid_cyc - last_cons_cyc), 32'd1);
        check({tag, ".meta_stable"}, 32'(stable), 32'd1);
        check({tag, ".csum_ok"}, 32'(snap_ok), 32'(exp_ok));
        check({tag, ".len_err"}, 32'(snap_err), 32'(exp_err));
        check({tag, ".drop"}, 32'(snap_drop), 32'(exp_drop));
        if (chk_fields) begin
            check({tag, ".src_port"}, {16'h0, snap_sp}, {16'h0, exp_sp});
            check({tag, ".dst_port"}, {16'h0, snap_dp}, {16'h0, exp_dp});
            check({tag, ".udp_len"}, {16'h0, snap_len}, {16'h0, exp_len});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
        in_meta_valid = 1'b0; in_proto = 8'h00; in_total = 16'h0;
        m_tready = 1'b1; udp_meta_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.s_tready", 32'(s_tready), 32'd0);
        check("rst.m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst.m_tlast", 32'(m_tlast), 32'd0);
        check("rst.m_tdata", {24'h0, m_tdata}, 32'd0);
        check("rst.meta_out", {13'h0, udp_meta_valid, in_meta_ready, csum_ok, len_err, drop,
                               13'h0}, 32'd0);
        check("rst.fields", {src_port, dst_port} | {16'h0, udp_len}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Valid 28-byte datagram, 20 payload bytes.
        build(16'h1234, 16'h0035, 16'd28, 20, 0, 1'b0);
        run_packet(8'h11, 16'd48, 1'b0, 0);
        check_result("good", 20, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0035, 16'd28);

        // One payload bit flipped after the checksum was computed.
        build(16'h1234, 16'h0035, 16'd28, 20, 0, 1'b0);
        pkt[13] = pkt[13] ^ 8'h01;
        run_packet(8'h11, 16'd48, 1'b0, 0);
        check_result("flip", 20, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0035, 16'd28);

        // Checksum not transmitted, odd length.
        build(16'hABCD, 16'h0444, 16'd29, 21, 0, 1'b1);
        run_packet(8'h11, 16'd49, 1'b0, 0);
        check_result("zero_ck", 21, 1'b1, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h0444, 16'd29);

        // Odd length with a real checksum: last byte padded low.
        build(16'h0F0F, 16'h8001, 16'd29, 21, 0, 1'b0);
        run_packet(8'h11, 16'd49, 1'b0, 0);
        check_result("odd_ck", 21, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0F0F, 16'h8001, 16'd29);

        // TCP packet is consumed and dropped.
        build(16'h1111, 16'h2222, 16'd28, 20, 0, 1'b0);
        run_packet(8'h06, 16'd48, 1'b0, 0);
        check_result("tcp", 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);

        // UDP length beyond the IPv4 payload.
        build(16'h5555, 16'h6666, 16'd40, 20, 0, 1'b1);
        run_packet(8'h11, 16'd48, 1'b0, 0);
        check_result("too_long", 0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h6666, 16'd40);

        // UDP length shorter than IPv4 payload: 8 padding bytes discarded.
        build(16'h7777, 16'h0808, 16'd20, 12, 8, 1'b0);
        run_packet(8'h11, 16'd48, 1'b0, 0);
        check_result("padded", 12, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0808, 16'd20);

        // Minimum length: header only, no payload.
        build(16'h0101, 16'h0202, 16'd8, 0, 0, 1'b0);
        run_packet(8'h11, 16'd28, 1'b0, 0);
        check_result("hdr_only", 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0101, 16'h0202, 16'd8);

        // Stream ends 4 bytes early inside the payload.
        build(16'h3333, 16'h4444, 16'd28, 16, 0, 1'b1);
        run_packet(8'h11, 16'd48, 1'b0, 0);
        check_result("early_end", 16, 1'b1, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 16'd28);

        // Random downstream backpressure and a 10-cycle metadata acknowledge delay.
        build(16'hBEEF, 16'hCAFE, 16'd28, 20, 0, 1'b0);
        run_packet(8'h11, 16'd48, 1'b1, 10);
        check_result("backpress", 20, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hCAFE, 16'd28);
        check("backpress.hold_cycles", 32'(meta_wait), 32'd11);

        // Reset in the middle of a header, then a clean datagram.
        in_proto = 8'h11; in_total = 16'd48; in_meta_valid = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'h12; s_tlast = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.s_tready", 32'(s_tready), 32'd0);
        in_meta_valid = 1'b0; s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build(16'h2468, 16'h1357, 16'd28, 20, 0, 1'b0);
        run_packet(8'h11, 16'd48, 1'b0, 0);
        check_result("after_rst", 20, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2468, 16'h1357, 16'd28);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
